// File: rtl/reg_file_2r1w_sb_pkg.sv
// reg_file_pkg: shared widths and types for the 2R/1W scoreboarded register file.
// Optional feature macro: REG_FILE_BYPASS_EN (write->read forwarding).
package reg_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;
  localparam int NREGS      = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
  typedef logic [NREGS-1:0]      busy_vec_t;

endpackage

// File: rtl/reg_file_2r1w_sb_if.sv
// reg_file_2r1w_sb_if: decode request/response, writeback and scoreboard signals.
// master = decode/writeback side, slave = register file.
interface reg_file_2r1w_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  localparam int NR = 2 ** ADDR_W;

  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] RA_ADDR;
  logic [ADDR_W-1:0] RB_ADDR;
  logic              DST_EN;
  logic [ADDR_W-1:0] DST_ADDR;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RA_DATA;
  logic [DATA_W-1:0] RB_DATA;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [NR-1:0]     BUSY;

  modport master (
    output REQ_VALID, RA_ADDR, RB_ADDR,
    output DST_EN, DST_ADDR,
    output WR_EN, WR_ADDR, WR_DATA,
    input  REQ_READY, RSP_VALID,
    input  RA_DATA, RB_DATA, BUSY
  );

  modport slave (
    input  REQ_VALID, RA_ADDR, RB_ADDR,
    input  DST_EN, DST_ADDR,
    input  WR_EN, WR_ADDR, WR_DATA,
    output REQ_READY, RSP_VALID,
    output RA_DATA, RB_DATA, BUSY
  );

endinterface

// File: rtl/reg_file_2r1w_sb_scoreboard.sv
// reg_file_scoreboard: per-register busy bits (set wins over clear) and REQ_READY.
// Ports: CLK/RST, read/dst addresses, accept, write strobe; busy_o, ready_o, fwd_*_o.
// REG_FILE_BYPASS_EN: a same-cycle write to a busy operand counts as not busy.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int NR     = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ra_i,
  input  logic [ADDR_W-1:0] rb_i,
  input  logic              dst_en_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic              acc_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  output logic [NR-1:0]     busy_o,
  output logic              ready_o,
  output logic              fwd_a_o,
  output logic              fwd_b_o
);

  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;
  logic [NR-1:0] clr_vec;
  logic [NR-1:0] set_vec;
  logic          wr_hit;
  logic          bsy_a;
  logic          bsy_b;
  logic          bsy_dst;

  assign wr_hit = wr_en_i && (wr_addr_i != '0);

  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_hit)
      clr_vec[wr_addr_i] = 1'b1;
    if (acc_i && dst_en_i && (dst_i != '0))
      set_vec[dst_i] = 1'b1;
  end

  // set applied after clear: a new reservation survives a same-edge write
  assign busy_d = (busy_q & ~clr_vec) | set_vec;

`ifdef REG_FILE_BYPASS_EN
  logic [NR-1:0] busy_post;

  assign busy_post = busy_q & ~clr_vec;
  assign bsy_a     = busy_post[ra_i];
  assign bsy_b     = busy_post[rb_i];
  assign bsy_dst   = busy_post[dst_i];
  assign fwd_a_o   = busy_q[ra_i] & clr_vec[ra_i];
  assign fwd_b_o   = busy_q[rb_i] & clr_vec[rb_i];
`else
  assign bsy_a     = busy_q[ra_i];
  assign bsy_b     = busy_q[rb_i];
  assign bsy_dst   = busy_q[dst_i];
  assign fwd_a_o   = 1'b0;
  assign fwd_b_o   = 1'b0;
`endif

  assign ready_o = !(bsy_a | bsy_b | (dst_en_i & bsy_dst));
  assign busy_o  = busy_q;

  always_ff @(negedge CLK) begin
    if (RST)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_file_2r1w_sb.sv
// reg_file_2r1w_sb: 2-read/1-write register file with busy scoreboard, 1-cycle read.
// Ports: CLK, RST (sync, active-high), bus (slave modport). State on falling CLK edge.
// REG_FILE_BYPASS_EN: forward WR_DATA to a read of a busy register being written.
module reg_file_2r1w_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic               CLK,
  input logic               RST,
  reg_file_2r1w_sb_if.slave bus
);

  localparam int NR = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NR];
  logic              rsp_valid_q;
  logic [DATA_W-1:0] ra_q;
  logic [DATA_W-1:0] rb_q;
  logic [DATA_W-1:0] ra_d;
  logic [DATA_W-1:0] rb_d;
  logic              ready;
  logic              acc;
  logic              wr_hit;
  logic              fwd_a;
  logic              fwd_b;
  logic [NR-1:0]     busy;

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .CLK       (CLK),
    .RST       (RST),
    .ra_i      (bus.RA_ADDR),
    .rb_i      (bus.RB_ADDR),
    .dst_en_i  (bus.DST_EN),
    .dst_i     (bus.DST_ADDR),
    .acc_i     (acc),
    .wr_en_i   (bus.WR_EN),
    .wr_addr_i (bus.WR_ADDR),
    .busy_o    (busy),
    .ready_o   (ready),
    .fwd_a_o   (fwd_a),
    .fwd_b_o   (fwd_b)
  );

  assign acc    = bus.REQ_VALID & ready;
  assign wr_hit = bus.WR_EN && (bus.WR_ADDR != '0);

  // storage reads return the pre-write value unless forwarding is active
  always_comb begin
    ra_d = '0;
    rb_d = '0;
    if (bus.RA_ADDR != '0)
      ra_d = regs_q[bus.RA_ADDR];
    if (bus.RB_ADDR != '0)
      rb_d = regs_q[bus.RB_ADDR];
    if (fwd_a)
      ra_d = bus.WR_DATA;
    if (fwd_b)
      rb_d = bus.WR_DATA;
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      rsp_valid_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      for (int i = 0; i < NR; i++)
        regs_q[i] <= '0;
    end else begin
      rsp_valid_q <= acc;
      if (acc) begin
        ra_q <= ra_d;
        rb_q <= rb_d;
      end
      if (wr_hit)
        regs_q[bus.WR_ADDR] <= bus.WR_DATA;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RA_DATA   = ra_q;
  assign bus.RB_DATA   = rb_q;
  assign bus.BUSY      = busy;

endmodule
